btn_cmd_arbiter: RTL

Multi-channel push-button front end. Each raw, asynchronous button input is synchronized, debounced and edge-detected, and the resulting press is recorded as a sticky request. A round-robin arbiter then issues the recorded presses one at a time as commands over a valid/ready handshake. The block sits between the board's button pins and the control FSM or counters that consume user commands, and replaces the per-button standalone synchronizer instances.

---
 rtl/btn_cmd_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/btn_cmd_arbiter.sv
// Push-button front end: per-channel synchronizer, debouncer and press detector
// feeding sticky requests into a round-robin valid/ready command issuer.
module btn_cmd_arbiter #(
    parameter int  N         = 4,
    parameter int  DB_CYCLES = 16,
    localparam int ID_W      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    btn_in,
    input  logic            cmd_ready,
    output logic            cmd_valid,
    output logic [ID_W-1:0] cmd_id,
    output logic [N-1:0]    btn_level,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overrun,
    output logic            arb_state
);

    localparam int                CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
    // cmd_valid and cmd_id stay constant from the offer until that edge.
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t          state, state_next;
    logic [N-1:0]    s1, s2;
    logic [CNT_W-1:0] cnt [N];
    logic [N-1:0]    rise, accept_clr;
    logic            accept, found, valid_next;
    logic [ID_W-1:0] ptr, ptr_next, id_next, sel, cand;

    assign arb_state = (state == OFFER);
    assign accept    = (state == OFFER) && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // A level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    btn_level[i] <= s2[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise       = '0;
        accept_clr = '0;
        for (int i = 0; i < N; i++) begin
            rise[i] = !btn_level[i] && s2[i] && (cnt[i] == CNT_MAX);
        end
        if (accept) accept_clr[cmd_id] = 1'b1;
    end

    // A press on the edge that accepts the same channel re-arms it without overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~accept_clr) | rise;
            overrun <= rise & pending & ~accept_clr;
        end
    end

    // Round-robin search: lowest offset from ptr wins, so iterate offsets downward.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % N);
            if (pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        id_next    = cmd_id;
        valid_next = cmd_valid;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = OFFER;
                    id_next    = sel;
                    valid_next = 1'b1;
                end
            end
            OFFER: begin
                if (cmd_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    ptr_next   = (cmd_id == ID_W'(N - 1)) ? '0 : cmd_id + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cmd_id    <= '0;
            cmd_valid <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            cmd_id    <= id_next;
            cmd_valid <= valid_next;
        end
    end

endmodule
